// File: rtl/mem_copy_pkg.sv
// Shared state encoding and default widths for the block-copy engine.
package mem_copy_pkg;

  localparam int DefaultW = 8;
  localparam int DefaultA = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_port_mux.sv
// Selects who drives the data memory port: the CPU when idle, the copy engine when busy.
module mem_port_mux #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Reset,
  input  logic         Busy,
  input  logic         CpuMemWrite,
  input  logic [A-1:0] CpuAddr,
  input  logic [W-1:0] CpuDataIn,
  input  logic         EngMemWrite,
  input  logic [A-1:0] EngAddr,
  input  logic [W-1:0] EngDataIn,
  output logic         MemWrite,
  output logic [A-1:0] DataAddress,
  output logic [W-1:0] DataIn
);

  // Reset suppresses any write so a transfer cut short leaves no partial byte behind.
  always_comb begin
    MemWrite    = Busy ? EngMemWrite : CpuMemWrite;
    DataAddress = Busy ? EngAddr : CpuAddr;
    DataIn      = Busy ? EngDataIn : CpuDataIn;
    if (Reset) begin
      MemWrite = 1'b0;
    end
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Byte-serial block-copy engine: one read cycle then one write cycle per byte,
// with the CPU's memory request passed straight through whenever the engine is not busy.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = DefaultW,
  parameter int A = DefaultA
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  input  logic         CpuMemWrite,
  input  logic [A-1:0] CpuAddr,
  input  logic [W-1:0] CpuDataIn,
  input  logic [W-1:0] MemDataOut,
  output logic         MemWrite,
  output logic [A-1:0] DataAddress,
  output logic [W-1:0] DataIn,
  output logic         Busy,
  output logic         Done
);

  copy_state_t  state_q;
  logic [A-1:0] srcAddr_q;
  logic [A-1:0] dstAddr_q;
  logic [A-1:0] len_q;
  logic [A-1:0] idx_q;
  logic [A-1:0] idx_d;
  logic [W-1:0] hold_q;

  logic         engMemWrite;
  logic [A-1:0] engAddr;

  assign idx_d = idx_q + A'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      srcAddr_q <= '0;
      dstAddr_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (Len != '0) begin
              srcAddr_q <= SrcAddr;
              dstAddr_q <= DstAddr;
              len_q     <= Len;
              idx_q     <= '0;
              state_q   <= READ;
            end else begin
              state_q <= DONE;
            end
          end
        end
        READ: begin
          hold_q  <= MemDataOut;
          state_q <= WRITE;
        end
        WRITE: begin
          idx_q   <= idx_d;
          state_q <= (idx_d == len_q) ? DONE : READ;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_q == READ) || (state_q == WRITE);
  assign Done = (state_q == DONE);

  // Addresses wrap modulo 2**A through plain A-bit addition.
  assign engMemWrite = (state_q == WRITE);
  assign engAddr     = ((state_q == WRITE) ? dstAddr_q : srcAddr_q) + idx_q;

  mem_port_mux #(
    .W(W),
    .A(A)
  ) portMux (
    .Reset      (Reset),
    .Busy       (Busy),
    .CpuMemWrite(CpuMemWrite),
    .CpuAddr    (CpuAddr),
    .CpuDataIn  (CpuDataIn),
    .EngMemWrite(engMemWrite),
    .EngAddr    (engAddr),
    .EngDataIn  (hold_q),
    .MemWrite   (MemWrite),
    .DataAddress(DataAddress),
    .DataIn     (DataIn)
  );

endmodule
